shift_reg_loader: RTL and testbench

Sequencer that feeds the 8-bit serial shift register. It accepts a parallel byte over a valid/ready handshake and serializes it onto `SER`. For each bit it issues a one-cycle `Shift_En` strobe at a programmable rate, so the register advances in the system clock domain without a derived clock. After the eighth shift it pulses `Done` and returns to idle.

---
 rtl/shift_reg_loader_if.sv | 22 ++
 rtl/shift_reg_loader.sv | 107 ++++++++++
 tb/tb_shift_reg_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/shift_reg_loader_if.sv
// Handshake and serial-output bundle between a byte producer and the shift register loader.
interface shift_reg_loader_if;
    logic [7:0] Din;
    logic       Load;
    logic       Clr;
    logic       Ready;
    logic       Busy;
    logic       SER;
    logic       Shift_En;
    logic       Done;
    logic [3:0] Bit_Cnt;

    modport master (
        output Din, Load, Clr,
        input  Ready, Busy, SER, Shift_En, Done, Bit_Cnt
    );

    modport slave (
        input  Din, Load, Clr,
        output Ready, Busy, SER, Shift_En, Done, Bit_Cnt
    );
endinterface

// File: rtl/shift_reg_loader.sv
// Serializes an accepted byte onto SER with one Shift_En strobe every DIV clocks,
// then pulses Done for one cycle and returns to idle.
module shift_reg_loader #(
    parameter int unsigned DIV       = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 Clk,
    input  logic                 RST,
    shift_reg_loader_if.slave    bus
);

    localparam int unsigned     PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    sh_q, sh_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          shift_en_q, shift_en_d;
    logic          ser_q, ser_d;
    logic          strobe;

    assign strobe = (state_q == SHIFT) && (presc_q == LAST);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        sh_d    = sh_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.Load && !bus.Clr) begin
                    sh_d    = bus.Din;
                    presc_d = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Clr wins over a coincident strobe: the count must not advance.
                if (bus.Clr) begin
                    presc_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
                    if (strobe) begin
                        sh_d  = MSB_FIRST ? {sh_q[6:0], 1'b0} : {1'b0, sh_q[7:1]};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                presc_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                presc_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Strobe and serial bit are computed one cycle early so both leave flops directly.
        shift_en_d = (state_d == SHIFT) && (presc_d == LAST);
        ser_d      = (state_d == SHIFT) ? (MSB_FIRST ? sh_d[7] : sh_d[0]) : 1'b0;
    end

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            presc_q    <= '0;
            cnt_q      <= '0;
            shift_en_q <= 1'b0;
            ser_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the same pre-edge values.
            state_q    <= state_d;
            sh_q       <= sh_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            shift_en_q <= shift_en_d;
            ser_q      <= ser_d;
        end
    end

    assign bus.Ready    = (state_q == IDLE);
    assign bus.Busy     = (state_q == SHIFT);
    assign bus.Done     = (state_q == DONE);
    assign bus.Shift_En = shift_en_q;
    assign bus.SER      = ser_q;
    assign bus.Bit_Cnt  = cnt_q;

endmodule

// File: tb/tb_shift_reg_loader.sv
// Directed bench for shift_reg_loader: four instances cover DIV 4/1/2/3 and both bit orders;
// expected serial bits are queued at stimulus time and popped on each observed Shift_En.
module tb_shift_reg_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] din [4];
    logic [3:0] load;
    logic [3:0] clr;
    wire  [3:0] ready, busy, ser, sen, done;
    wire  [3:0] bcnt [4];

    int total = 0;
    int bad   = 0;
    bit exp_q [$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        shift_reg_loader_if bus_if ();

        assign bus_if.Din  = din[g];
        assign bus_if.Load = load[g];
        assign bus_if.Clr  = clr[g];
        assign ready[g]    = bus_if.Ready;
        assign busy[g]     = bus_if.Busy;
        assign ser[g]      = bus_if.SER;
        assign sen[g]      = bus_if.Shift_En;
        assign done[g]     = bus_if.Done;
        assign bcnt[g]     = bus_if.Bit_Cnt;

        shift_reg_loader #(
            .DIV       ((g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 3),
            .MSB_FIRST ((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .Clk (clk),
            .RST (rst_n),
            .bus (bus_if)
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int k, input string where);
        check($sformatf("i%0d %s ready", k, where), ready[k], 1);
        check($sformatf("i%0d %s busy", k, where), busy[k], 0);
        check($sformatf("i%0d %s shift_en", k, where), sen[k], 0);
        check($sformatf("i%0d %s ser", k, where), ser[k], 0);
        check($sformatf("i%0d %s done", k, where), done[k], 0);
        check($sformatf("i%0d %s bit_cnt", k, where), bcnt[k], 0);
    endtask

    // One transfer on instance k. hold keeps Load high (with nd on Din) after acceptance.
    // stop_c > 0 interrupts after the checks of that cycle: Clr, or async reset if stop_rst.
    task automatic xfer(input int k, input int div, input bit msb, input logic [7:0] d,
                        input bit hold, input logic [7:0] nd,
                        input int stop_c, input bit stop_rst);
        bit stopped = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(msb ? d[7-i] : d[i]);
        din[k]  = d;
        load[k] = 1'b1;
        @(posedge clk);
        #1;
        load[k] = hold;
        din[k]  = hold ? nd : ~d;
        for (int c = 1; c <= 8 * div + 1; c++) begin
            @(negedge clk);
            if (stopped) begin
                check_idle(k, $sformatf("c%0d after stop", c));
                break;
            end
            check($sformatf("i%0d c%0d shift_en", k, c), sen[k], (c % div == 0) && (c <= 8 * div));
            if (sen[k] === 1'b1) begin
                check($sformatf("i%0d c%0d sb_nonempty", k, c), exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check($sformatf("i%0d c%0d ser", k, c), ser[k], exp_q.pop_front());
            end
            check($sformatf("i%0d c%0d bit_cnt", k, c), bcnt[k], (c - 1) / div);
            check($sformatf("i%0d c%0d busy", k, c), busy[k], c <= 8 * div);
            check($sformatf("i%0d c%0d done", k, c), done[k], c == 8 * div + 1);
            check($sformatf("i%0d c%0d ready", k, c), ready[k], 0);
            if (c == stop_c) begin
                stopped = 1'b1;
                if (stop_rst) begin
                    #2 rst_n = 1'b0;
                    #1 check_idle(k, "async reset");
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    clr[k] = 1'b1;
                end
            end
        end
        if (stopped) begin
            clr[k] = 1'b0;
            exp_q.delete();
            @(negedge clk);
            check_idle(k, "stop settle");
        end else begin
            check($sformatf("i%0d sb_empty", k), exp_q.size(), 0);
            @(negedge clk);
            check_idle(k, "post done");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        load  = '0;
        clr   = '0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) check_idle(k, "in reset");
        rst_n = 1'b1;
        @(negedge clk);

        // MSB-first, DIV=4, A5
        xfer(0, 4, 1'b1, 8'hA5, 1'b0, 8'h00, 0, 1'b0);
        // LSB-first, DIV=1, 01
        xfer(1, 1, 1'b0, 8'h01, 1'b0, 8'h00, 0, 1'b0);
        // Back-to-back, DIV=2, Load held through the first transfer
        xfer(2, 2, 1'b1, 8'hFF, 1'b1, 8'h00, 0, 1'b0);
        xfer(2, 2, 1'b1, 8'h00, 1'b0, 8'h00, 0, 1'b0);

        // Clr in IDLE blocks a concurrent Load
        din[2]  = 8'h3C;
        load[2] = 1'b1;
        clr[2]  = 1'b1;
        @(negedge clk);
        check_idle(2, "clr blocks load");
        load[2] = 1'b0;
        clr[2]  = 1'b0;
        @(negedge clk);

        // Abort during strobe 5, then a fresh transfer
        xfer(0, 4, 1'b1, 8'h96, 1'b0, 8'h00, 20, 1'b0);
        xfer(0, 4, 1'b1, 8'h5A, 1'b0, 8'h00, 0, 1'b0);

        // Async reset at Bit_Cnt=3 (DIV=3), then a full transfer stepping Bit_Cnt 0..8
        xfer(3, 3, 1'b1, 8'hC3, 1'b0, 8'h00, 10, 1'b1);
        xfer(3, 3, 1'b1, 8'h6B, 1'b0, 8'h00, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
